datapath_gray_pipe: RTL and testbench

Parametrised, pipelined successor of the fixed 24-bit RGB-to-gray converter. Converts packed {R,G,B} pixels of CW bits per component into one CW-bit gray value per pixel. The conversion mode is selectable per frame. The block propagates start-of-frame, honours downstream backpressure without losing pixels, and flags frames whose pixel count differs from FRAME_PIX. It sits in the streaming video datapath between the pixel source and any CW-bit consumer.

---
 rtl/gray_pkg.sv | 21 ++
 rtl/gray_skid_buf.sv | 69 ++++++
 rtl/datapath_gray_pipe.sv | 184 ++++++++++++++++++
 tb/tb_datapath_gray_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and conversion constants for the pipelined RGB-to-gray datapath.
package gray_pkg;

  typedef enum logic [1:0] {
    GRAY_LUMA  = 2'd0,
    GRAY_AVG   = 2'd1,
    GRAY_GREEN = 2'd2,
    GRAY_MAX   = 2'd3
  } gray_mode_e;

  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_ROUND = 128;
  localparam int unsigned LUMA_SHIFT = 8;

  localparam int unsigned AVG_MUL    = 171;
  localparam int unsigned AVG_ROUND  = 256;
  localparam int unsigned AVG_SHIFT  = 9;

endpackage

// File: rtl/gray_skid_buf.sv
// Two-entry valid/busy skid buffer with a registered busy towards the source.
module gray_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_busy,
  output logic         out_valid_c,
  output logic [W-1:0] out_data,
  input  logic         out_busy
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         busy_q, busy_d;
  logic         push_c, pop_c;

  // Second entry catches the word accepted in the cycle a stall begins.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    push_c = in_valid && !busy_q;
    pop_c  = (cnt_q != 2'd0) && !out_busy;
    case ({push_c, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
    busy_d = (cnt_d == 2'd2) || ((cnt_d == 2'd1) && out_busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
    end
  end

  assign in_busy     = busy_q;
  assign out_valid_c = (cnt_q != 2'd0);
  assign out_data    = head_q;

endmodule

// File: rtl/datapath_gray_pipe.sv
// Pipelined {R,G,B} to gray converter with per-frame mode, backpressure and
// frame-length checking: skid buffer -> S1 operands -> S2 arithmetic -> S3 output.
module datapath_gray_pipe
  import gray_pkg::*;
#(
  parameter int unsigned CW        = 8,
  parameter int unsigned FRAME_PIX = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3*CW-1:0]   data_in,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic [1:0]        i_mode,
  output logic              busy_out,
  output logic [CW-1:0]     data_out,
  output logic              valid_out,
  output logic              sof_out,
  input  logic              busy_in,
  output logic              o_frame_err,
  output logic [CNT_W-1:0]  o_pix_cnt
);

  localparam int unsigned PIX_W  = 3 * CW;
  localparam int unsigned SUM_W  = CW + 10;
  localparam int unsigned SKID_W = 2 + 1 + PIX_W;

  typedef struct packed {
    gray_mode_e       mode;
    logic             sof;
    logic [PIX_W-1:0] pix;
  } pix_word_t;

  // Front end
  gray_mode_e       mode_q, mode_d;
  logic             in_frame_q, in_frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_xfer_c, push_c;
  pix_word_t        push_word_c;

  // Skid buffer
  logic             skid_busy, skid_valid_c;
  pix_word_t        skid_word;

  // Pipeline stages
  logic             s1_v_q, s1_v_d;
  pix_word_t        s1_w_q, s1_w_d;
  logic             s2_v_q, s2_v_d;
  logic             s2_sof_q, s2_sof_d;
  logic [SUM_W-1:0] s2_val_q, s2_val_d;
  logic             s3_v_q, s3_v_d;
  logic             s3_sof_q, s3_sof_d;
  logic [CW-1:0]    s3_data_q, s3_data_d;
  logic             s1_ld_c, s2_ld_c, s3_ld_c;

  logic [SUM_W-1:0] r_c, g_c, b_c, luma_c, avg_c, max_c, gray_c;

  // Mode latch, pre-SOF discard and frame-length bookkeeping.
  always_comb begin
    mode_d      = mode_q;
    in_frame_d  = in_frame_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    push_c      = 1'b0;
    in_xfer_c   = valid_in && !skid_busy;
    push_word_c = '{mode: mode_q, sof: sof_in, pix: data_in};
    if (in_xfer_c && sof_in) begin
      mode_d           = gray_mode_e'(i_mode);
      push_word_c.mode = gray_mode_e'(i_mode);
      in_frame_d       = 1'b1;
      cnt_d            = CNT_W'(1);
      push_c           = 1'b1;
      err_d            = in_frame_q && (FRAME_PIX != 0) && (cnt_q != CNT_W'(FRAME_PIX));
    end else if (in_xfer_c && in_frame_q) begin
      push_c = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= GRAY_LUMA;
      in_frame_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      in_frame_q <= in_frame_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  gray_skid_buf #(.W(SKID_W)) u_skid (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .in_valid    (push_c),
    .in_data     (push_word_c),
    .in_busy     (skid_busy),
    .out_valid_c (skid_valid_c),
    .out_data    (skid_word),
    .out_busy    (!s1_ld_c)
  );

  // S2 arithmetic, widened so no intermediate can overflow.
  always_comb begin
    r_c    = SUM_W'(s1_w_q.pix[PIX_W-1 -: CW]);
    g_c    = SUM_W'(s1_w_q.pix[2*CW-1 -: CW]);
    b_c    = SUM_W'(s1_w_q.pix[CW-1:0]);
    luma_c = (r_c * SUM_W'(LUMA_R) + g_c * SUM_W'(LUMA_G) + b_c * SUM_W'(LUMA_B)
              + SUM_W'(LUMA_ROUND)) >> LUMA_SHIFT;
    avg_c  = ((r_c + g_c + b_c) * SUM_W'(AVG_MUL) + SUM_W'(AVG_ROUND)) >> AVG_SHIFT;
    max_c  = r_c;
    if (g_c > max_c) max_c = g_c;
    if (b_c > max_c) max_c = b_c;
    case (s1_w_q.mode)
      GRAY_LUMA:  gray_c = luma_c;
      GRAY_AVG:   gray_c = avg_c;
      GRAY_GREEN: gray_c = g_c;
      default:    gray_c = max_c;
    endcase
  end

  // Each stage loads when it is empty or its successor is moving on.
  always_comb begin
    s3_ld_c   = !s3_v_q || !busy_in;
    s2_ld_c   = !s2_v_q || s3_ld_c;
    s1_ld_c   = !s1_v_q || s2_ld_c;
    s1_v_d    = s1_v_q;
    s1_w_d    = s1_w_q;
    s2_v_d    = s2_v_q;
    s2_sof_d  = s2_sof_q;
    s2_val_d  = s2_val_q;
    s3_v_d    = s3_v_q;
    s3_sof_d  = s3_sof_q;
    s3_data_d = s3_data_q;
    if (s1_ld_c) begin
      s1_v_d = skid_valid_c;
      s1_w_d = skid_word;
    end
    if (s2_ld_c) begin
      s2_v_d   = s1_v_q;
      s2_sof_d = s1_w_q.sof;
      s2_val_d = gray_c;
    end
    if (s3_ld_c) begin
      s3_v_d    = s2_v_q;
      s3_sof_d  = s2_sof_q;
      s3_data_d = (s2_val_q > SUM_W'({CW{1'b1}})) ? {CW{1'b1}} : s2_val_q[CW-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v_q    <= 1'b0;
      s1_w_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_sof_q  <= 1'b0;
      s2_val_q  <= '0;
      s3_v_q    <= 1'b0;
      s3_sof_q  <= 1'b0;
      s3_data_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_w_q    <= s1_w_d;
      s2_v_q    <= s2_v_d;
      s2_sof_q  <= s2_sof_d;
      s2_val_q  <= s2_val_d;
      s3_v_q    <= s3_v_d;
      s3_sof_q  <= s3_sof_d;
      s3_data_q <= s3_data_d;
    end
  end

  assign busy_out    = skid_busy;
  assign data_out    = s3_data_q;
  assign valid_out   = s3_v_q && (s3_sof_q || !s3_sof_q);
  assign sof_out     = s3_sof_q && s3_v_q;
  assign o_frame_err = err_q;
  assign o_pix_cnt   = cnt_q;

endmodule

// File: tb/tb_datapath_gray_pipe.sv
// Randomised self-checking bench for datapath_gray_pipe against a frame-level reference model.
module tb_datapath_gray_pipe;

  localparam int unsigned CW        = 8;
  localparam int unsigned FRAME_PIX = 16;
  localparam int unsigned CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3*CW-1:0]   data_in;
  logic              valid_in;
  logic              sof_in;
  logic [1:0]        i_mode;
  logic              busy_out;
  logic [CW-1:0]     data_out;
  logic              valid_out;
  logic              sof_out;
  logic              busy_in = 1'b0;
  logic              o_frame_err;
  logic [CNT_W-1:0]  o_pix_cnt;

  datapath_gray_pipe #(.CW(CW), .FRAME_PIX(FRAME_PIX), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .sof_in      (sof_in),
    .i_mode      (i_mode),
    .busy_out    (busy_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .sof_out     (sof_out),
    .busy_in     (busy_in),
    .o_frame_err (o_frame_err),
    .o_pix_cnt   (o_pix_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int ref_gray(input logic [23:0] p, input logic [1:0] m);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (m)
      2'd0:    y = (77 * r + 150 * g + 29 * b + 128) / 256;
      2'd1:    y = ((r + g + b) * 171 + 256) / 512;
      2'd2:    y = g;
      default: y = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
    endcase
    if (y > 255) y = 255;
    return y;
  endfunction

  // Reference model state: what the block should hold after each clock edge.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  bit         cap_en    = 1'b0;
  bit         m_in_frame;
  logic [1:0] m_mode;
  int         m_cnt;
  bit         m_err;
  bit         prev_hold;
  logic [7:0] prev_data;
  logic       prev_sof;
  bit         prev_busy_in = 1'b1;
  int         bmode = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_in_frame   = 1'b0;
      m_mode       = 2'd0;
      m_cnt        = 0;
      m_err        = 1'b0;
      prev_hold    = 1'b0;
      prev_busy_in = 1'b1;
      check("rst_valid_out", 64'(valid_out), 64'd0);
      check("rst_pix_cnt", 64'(o_pix_cnt), 64'd0);
    end else begin
      check("pix_cnt", 64'(o_pix_cnt), 64'(m_cnt));
      check("frame_err", 64'(o_frame_err), 64'(m_err));
      if (prev_hold) begin
        check("hold_valid", 64'(valid_out), 64'd1);
        check("hold_data", 64'(data_out), 64'(prev_data));
        check("hold_sof", 64'(sof_out), 64'(prev_sof));
      end
      if (!prev_busy_in) check("busy_out_room", 64'(busy_out), 64'd0);
      if (valid_out && !busy_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(data_out), 64'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(data_out), 64'(e[7:0]));
          check("out_sof", 64'(sof_out), 64'(e[8]));
          if (cap_en) got_q.push_back({sof_out, data_out});
        end
      end
      m_err = 1'b0;
      if (valid_in && !busy_out) begin
        if (sof_in) begin
          m_err      = m_in_frame && (FRAME_PIX != 0) && (m_cnt != FRAME_PIX);
          m_in_frame = 1'b1;
          m_mode     = i_mode;
          m_cnt      = 1;
          exp_q.push_back({1'b1, 8'(ref_gray(data_in, i_mode))});
        end else if (m_in_frame) begin
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          exp_q.push_back({1'b0, 8'(ref_gray(data_in, m_mode))});
        end
      end
      prev_hold    = valid_out && busy_in;
      prev_data    = data_out;
      prev_sof     = sof_out;
      prev_busy_in = busy_in;
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (bmode)
      0:       busy_in = 1'b0;
      1:       busy_in = ($urandom_range(0, 2) == 0);
      default: busy_in = 1'b1;
    endcase
  end

  task automatic send(input logic [23:0] p, input logic s, input logic [1:0] m);
    int n;
    n        = 0;
    valid_in = 1'b1;
    data_in  = p;
    sof_in   = s;
    i_mode   = m;
    @(negedge clk);
    while (busy_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_out) check("send_timeout", 64'(busy_out), 64'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    idle(1);
  endtask

  task automatic send_frame(input int n, input logic [1:0] m, input bit do_chk, input bit exp_err);
    send(24'($urandom), 1'b1, m);
    if (do_chk) begin
      @(negedge clk);
      check("sof_frame_err", 64'(o_frame_err), 64'(exp_err));
      @(posedge clk);
      #1;
    end
    for (int i = 1; i < n; i++) begin
      send(24'($urandom), 1'b0, m);
      if (bmode == 1 && $urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  logic [8:0] exp1[6];
  logic [8:0] exp2[6];

  initial begin
    exp1 = '{9'h1FF, 9'h0E2, 9'h04D, 9'h000, 9'h01D, 9'h095};
    exp2 = '{9'h164, 9'h0FF, 9'h001, 9'h1AB, 9'h1AB, 9'h080};
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    data_in  = '0;
    i_mode   = 2'd0;
    idle(3);
    check("reset_busy_out", 64'(busy_out), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_frame_err", 64'(o_frame_err), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed luma sequence, no backpressure
    cap_en = 1'b1;
    send(24'hFFFFFF, 1'b1, 2'd0);
    send(24'hFFFF00, 1'b0, 2'd0);
    send(24'hFF0000, 1'b0, 2'd0);
    send(24'h000000, 1'b0, 2'd0);
    send(24'h0000FF, 1'b0, 2'd0);
    send(24'h00FF00, 1'b0, 2'd0);
    drain();
    check("t1_count", 64'(got_q.size()), 64'd6);
    if (got_q.size() == 6)
      for (int i = 0; i < 6; i++) check("t1_pixel", 64'(got_q[i]), 64'(exp1[i]));
    got_q.delete();

    // Directed average / green / max
    send(24'h646464, 1'b1, 2'd1);
    send(24'hFFFFFF, 1'b0, 2'd1);
    send(24'h030000, 1'b0, 2'd1);
    send(24'h12AB34, 1'b1, 2'd2);
    send(24'h12AB34, 1'b1, 2'd3);
    send(24'h80107F, 1'b0, 2'd3);
    drain();
    cap_en = 1'b0;
    check("t2_count", 64'(got_q.size()), 64'd6);
    if (got_q.size() == 6)
      for (int i = 0; i < 6; i++) check("t2_pixel", 64'(got_q[i]), 64'(exp2[i]));

    // Frame-length checking
    send_frame(16, 2'd0, 1'b0, 1'b0);
    idle(2);
    check("cnt_16", 64'(o_pix_cnt), 64'd16);
    send_frame(15, 2'd1, 1'b1, 1'b0);
    idle(2);
    check("cnt_15", 64'(o_pix_cnt), 64'd15);
    send_frame(17, 2'd2, 1'b1, 1'b1);
    idle(2);
    check("cnt_17", 64'(o_pix_cnt), 64'd17);
    send_frame(16, 2'd0, 1'b1, 1'b1);
    send_frame(16, 2'd3, 1'b0, 1'b0);
    drain();

    // Random backpressure over several frames
    bmode = 1;
    for (int f = 0; f < 6; f++) send_frame(16, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    bmode = 0;
    drain();

    // Reset mid-frame during a stall
    bmode = 2;
    idle(1);
    send_frame(5, 2'd3, 1'b0, 1'b0);
    valid_in = 1'b1;
    data_in  = 24'hABCDEF;
    sof_in   = 1'b0;
    idle(2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(valid_out), 64'd0);
    check("rst_mid_busy", 64'(busy_out), 64'd0);
    check("rst_mid_data", 64'(data_out), 64'd0);
    check("rst_mid_cnt", 64'(o_pix_cnt), 64'd0);
    valid_in = 1'b0;
    bmode    = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, 2'd0);
    idle(6);
    check("noframe_cnt", 64'(o_pix_cnt), 64'd0);
    check("noframe_valid", 64'(valid_out), 64'd0);
    send(24'h336699, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("latency", 64'(valid_out), 64'(i == 3));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
